// File: rtl/state_pkg.sv
// Shared constants and FSM encoding for the GA sequencer.
package state_pkg;
    localparam int POP_W = 7501;

    typedef enum logic [1:0] {
        RESET_LAUNCH = 2'd0,
        INIT_WAIT    = 2'd1,
        SEL_WAIT     = 2'd2,
        MUT_WAIT     = 2'd3
    } fsm_t;
endpackage

// File: rtl/state_if.sv
// Population buses and stage start/done handshakes between the sequencer and its stages.
interface state_if
    import state_pkg::*;
#(
    parameter int POP_W = state_pkg::POP_W
);
    logic [POP_W-1:0] in_pop;
    logic [POP_W-1:0] mut_pop;
    logic [POP_W-1:0] population;
    logic             in_done;
    logic             sel_done;
    logic             mut_done;
    logic             in_start;
    logic             sel_start;
    logic             mut_start;

    modport master (
        output in_pop, mut_pop, in_done, sel_done, mut_done,
        input  population, in_start, sel_start, mut_start
    );

    modport slave (
        input  in_pop, mut_pop, in_done, sel_done, mut_done,
        output population, in_start, sel_start, mut_start
    );
endinterface

// File: rtl/state_rise_detect.sv
// Rising-edge detector for a level done signal: rise = d & ~d_q.
// Latency: combinational from d; history register clears on reset. No backpressure.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/state.sv
// GA sequencer: launches init, then loops selection/mutation, holding the population.
// Latency: start pulses and population loads appear one edge after the done rise.
// Backpressure: none; a stage is only started after its predecessor reports done.
module state
    import state_pkg::*;
#(
    parameter int POP_W = state_pkg::POP_W
) (
    input  logic clk,
    input  logic rst,
    state_if.slave bus
);
    fsm_t             state_q, state_d;
    logic [POP_W-1:0] pop_q, pop_d;
    logic             in_start_q, in_start_d;
    logic             sel_start_q, sel_start_d;
    logic             mut_start_q, mut_start_d;
    logic             in_rise, sel_rise, mut_rise;

    rise_detect u_in_rise  (.clk(clk), .rst(rst), .d(bus.in_done),  .rise(in_rise));
    rise_detect u_sel_rise (.clk(clk), .rst(rst), .d(bus.sel_done), .rise(sel_rise));
    rise_detect u_mut_rise (.clk(clk), .rst(rst), .d(bus.mut_done), .rise(mut_rise));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_LAUNCH;
            pop_q       <= '0;
            in_start_q  <= 1'b0;
            sel_start_q <= 1'b0;
            mut_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pop_q       <= pop_d;
            in_start_q  <= in_start_d;
            sel_start_q <= sel_start_d;
            mut_start_q <= mut_start_d;
        end
    end

    // Only the awaited stage's rise is looked at; other rises fall through and are lost.
    always_comb begin
        state_d     = state_q;
        pop_d       = pop_q;
        in_start_d  = 1'b0;
        sel_start_d = 1'b0;
        mut_start_d = 1'b0;
        unique case (state_q)
            RESET_LAUNCH: begin
                in_start_d = 1'b1;
                state_d    = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (in_rise) begin
                    pop_d       = bus.in_pop;
                    sel_start_d = 1'b1;
                    state_d     = SEL_WAIT;
                end
            end
            SEL_WAIT: begin
                if (sel_rise) begin
                    mut_start_d = 1'b1;
                    state_d     = MUT_WAIT;
                end
            end
            MUT_WAIT: begin
                if (mut_rise) begin
                    pop_d       = bus.mut_pop;
                    sel_start_d = 1'b1;
                    state_d     = SEL_WAIT;
                end
            end
            default: state_d = RESET_LAUNCH;
        endcase
    end

    assign bus.population = pop_q;
    assign bus.in_start   = in_start_q;
    assign bus.sel_start  = sel_start_q;
    assign bus.mut_start  = mut_start_q;
endmodule

// File: tb/tb_state.sv
// Directed bench for the GA sequencer: reset, init load, gen loop, stray dones, mid-run reset.
module tb_state;
    import state_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   in_cnt, sel_cnt, mut_cnt, multi_cnt;
    int   snap;

    logic [POP_W-1:0] pop_zero;
    logic [POP_W-1:0] pop_one;
    logic [POP_W-1:0] pat_a;
    logic [POP_W-1:0] pat_b;

    state_if #(.POP_W(POP_W)) bus ();

    state #(.POP_W(POP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, sample 1 ns later and tally start pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        in_cnt  += int'(bus.in_start);
        sel_cnt += int'(bus.sel_start);
        mut_cnt += int'(bus.mut_start);
        if ((int'(bus.in_start) + int'(bus.sel_start) + int'(bus.mut_start)) > 1)
            multi_cnt++;
    endtask

    function automatic int total_starts();
        return in_cnt + sel_cnt + mut_cnt;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [POP_W-1:0] exp);
        tests++;
        assert (bus.population === exp) else begin
            fails++;
            $error("FAIL %s observed(low64)=%h expected(low64)=%h", tag,
                   bus.population[63:0], exp[63:0]);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        in_cnt = 0; sel_cnt = 0; mut_cnt = 0; multi_cnt = 0;
        pop_zero = '0;
        pop_one  = '0;
        pop_one[0] = 1'b1;
        for (int i = 0; i < POP_W; i++) begin
            pat_a[i] = ((i % 3) == 0);
            pat_b[i] = ((i % 5) == 1) || (i == POP_W - 1);
        end

        rst = 1'b1;
        bus.in_pop = pop_zero;
        bus.mut_pop = pop_one;
        bus.in_done = 1'b0;
        bus.sel_done = 1'b0;
        bus.mut_done = 1'b0;

        // Reset held 3 cycles
        repeat (3) tick();
        check_bit("rst_in_start", bus.in_start, 1'b0);
        check_bit("rst_sel_start", bus.sel_start, 1'b0);
        check_bit("rst_mut_start", bus.mut_start, 1'b0);
        check_pop("rst_population", pop_zero);
        in_cnt = 0; sel_cnt = 0; mut_cnt = 0; multi_cnt = 0;

        rst = 1'b0;
        tick();
        check_bit("launch_in_start", bus.in_start, 1'b1);
        check_bit("launch_sel_start", bus.sel_start, 1'b0);
        check_bit("launch_mut_start", bus.mut_start, 1'b0);
        check_pop("launch_population", pop_zero);
        tick();
        check_bit("launch_in_start_one_cycle", bus.in_start, 1'b0);

        // Init load, in_done held 10 cycles
        bus.in_done = 1'b1;
        tick();
        check_bit("init_sel_start", bus.sel_start, 1'b1);
        check_pop("init_population", pop_zero);
        snap = total_starts();
        repeat (9) tick();
        bus.in_done = 1'b0;
        tick();
        check_int("init_no_extra_pulses", total_starts() - snap, 0);

        // Three generations of sel/mut
        for (int g = 0; g < 3; g++) begin
            bus.sel_done = 1'b1;
            tick();
            check_bit("loop_mut_start", bus.mut_start, 1'b1);
            check_bit("loop_sel_start_low", bus.sel_start, 1'b0);
            check_pop("loop_pop_after_sel", (g == 0) ? pop_zero : pop_one);
            snap = total_starts();
            repeat (9) tick();
            bus.sel_done = 1'b0;
            repeat (10) tick();
            check_int("loop_sel_hold_quiet", total_starts() - snap, 0);
            bus.mut_done = 1'b1;
            tick();
            check_bit("loop_sel_start", bus.sel_start, 1'b1);
            check_pop("loop_pop_after_mut", pop_one);
            snap = total_starts();
            repeat (9) tick();
            bus.mut_done = 1'b0;
            tick();
            check_int("loop_mut_hold_quiet", total_starts() - snap, 0);
        end
        check_int("loop_in_count", in_cnt, 1);
        check_int("loop_sel_count", sel_cnt, 4);
        check_int("loop_mut_count", mut_cnt, 3);

        // Stray dones in SEL_WAIT, inputs changing underneath
        bus.in_pop = pat_a;
        bus.mut_pop = pat_b;
        bus.mut_done = 1'b1;
        bus.in_done = 1'b1;
        snap = total_starts();
        repeat (5) tick();
        check_int("stray_no_pulses", total_starts() - snap, 0);
        check_pop("stray_pop_hold", pop_one);

        // sel_done and mut_done rising together: only sel is acted on
        bus.in_done = 1'b0;
        bus.mut_done = 1'b0;
        tick();
        bus.sel_done = 1'b1;
        bus.mut_done = 1'b1;
        tick();
        check_bit("simul_mut_start", bus.mut_start, 1'b1);
        check_bit("simul_sel_start", bus.sel_start, 1'b0);
        tick();
        check_bit("simul_mut_held_ignored", bus.sel_start, 1'b0);
        check_pop("simul_pop_hold", pop_one);

        // Mid-run reset from MUT_WAIT with mut_done still high
        rst = 1'b1;
        tick();
        check_pop("midrst_population", pop_zero);
        check_bit("midrst_sel_start", bus.sel_start, 1'b0);
        check_bit("midrst_mut_start", bus.mut_start, 1'b0);
        rst = 1'b0;
        bus.sel_done = 1'b0;
        tick();
        check_bit("midrst_in_start", bus.in_start, 1'b1);
        bus.mut_done = 1'b0;
        tick();
        bus.mut_done = 1'b1;
        snap = total_starts();
        tick();
        check_int("midrst_mut_ignored_init", total_starts() - snap, 0);
        check_pop("midrst_pop_still_zero", pop_zero);

        bus.in_done = 1'b1;
        tick();
        check_bit("reinit_sel_start", bus.sel_start, 1'b1);
        check_pop("reinit_pop_load", pat_a);
        bus.mut_done = 1'b0;
        tick();
        bus.mut_done = 1'b1;
        snap = total_starts();
        tick();
        check_int("reinit_mut_ignored_sel", total_starts() - snap, 0);
        bus.sel_done = 1'b1;
        tick();
        check_bit("reinit_mut_start", bus.mut_start, 1'b1);
        tick();
        check_bit("reinit_mut_high_no_rise", bus.sel_start, 1'b0);
        check_pop("reinit_pop_hold", pat_a);
        bus.mut_done = 1'b0;
        tick();
        bus.mut_done = 1'b1;
        tick();
        check_bit("reinit_mut_sel_start", bus.sel_start, 1'b1);
        check_pop("reinit_mut_pop_load", pat_b);

        check_int("one_hot_starts", multi_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/state.md
STATE -- requirements
Module: state

Interface
REQ-001 Parameter POP_W, default 7501, width in bits of one packed population vector.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 in_pop  input  POP_W  initial population from the initializer stage.
REQ-005 mut_pop  input  POP_W  population returned by the mutation stage.
REQ-006 in_done  input  1  initializer finished (level; acted on at its rising edge).
REQ-007 sel_done  input  1  selection stage finished (level; acted on at its rising edge).
REQ-008 mut_done  input  1  mutation stage finished (level; acted on at its rising edge).
REQ-009 population  output  POP_W  current population register.
REQ-010 in_start  output  1  single-cycle start pulse to the initializer.
REQ-011 sel_start  output  1  single-cycle start pulse to the selection stage.
REQ-012 mut_start  output  1  single-cycle start pulse to the mutation stage.

Function
REQ-013 The FSM SHALL have four states: RESET_LAUNCH, INIT_WAIT, SEL_WAIT, MUT_WAIT.
REQ-014 All outputs SHALL be registered; no combinational input-to-output paths.
REQ-015 A done input SHALL count as an event only on a rising edge: done=1 this cycle while its registered copy done_q=0.
REQ-016 RESET_LAUNCH: on the first edge with rst=0, in_start SHALL be driven 1 and the FSM SHALL move to INIT_WAIT.
REQ-017 INIT_WAIT: on an in_done rising edge, population SHALL load in_pop, sel_start SHALL be driven 1, and the FSM SHALL move to SEL_WAIT.
REQ-018 SEL_WAIT: on a sel_done rising edge, mut_start SHALL be driven 1, the FSM SHALL move to MUT_WAIT, and population SHALL be unchanged.
REQ-019 MUT_WAIT: on a mut_done rising edge, population SHALL load mut_pop, sel_start SHALL be driven 1, and the FSM SHALL move to SEL_WAIT.
REQ-020 The SEL/MUT loop SHALL repeat indefinitely with no generation limit.
REQ-021 Each start output SHALL be high for exactly one cycle, on the edge after the triggering done edge (one-cycle latency), and 0 otherwise.
REQ-022 At most one start output SHALL be high in any cycle.
REQ-023 A done rising edge for a stage other than the one being waited on SHALL be ignored, including one that occurs simultaneously with the awaited done.
REQ-024 A done held high across many cycles SHALL produce exactly one transition.
REQ-025 While waiting, population SHALL hold its value regardless of in_pop and mut_pop.

Reset
REQ-026 With rst=1 at a clock edge: FSM goes to RESET_LAUNCH, population goes to 0, all start outputs go to 0, and all done_q registers go to 0.
REQ-027 Reset asserted mid-operation SHALL abort the current stage and restart from RESET_LAUNCH, issuing a fresh in_start pulse after release.
REQ-028 A done input already high when reset is released SHALL be treated as a rising edge, because done_q resets to 0.

Structure
REQ-029 A shared package SHALL hold POP_W and the FSM state enum (2-bit encoding).
REQ-030 Done edge detection SHALL be done by a single sub-module, rise_detect, instantiated three times.

Verification
REQ-031 Reset test: rst=1 for 3 cycles, then 0 -> in_start=1 for exactly the first post-reset cycle; population=0; sel_start=0 and mut_start=0.
REQ-032 Init load test: in_pop=0, in_done high for 10 cycles -> population=0; one sel_start pulse one cycle after the in_done rise; no further pulses.
REQ-033 Loop test: mut_pop=1; run three generations of sel_done pulse, 10 cycles low, mut_done pulse, each held 10 cycles -> three mut_start and three sel_start pulses (plus the init one); population=1 after the first mut_done.
REQ-034 Stray-done test: in SEL_WAIT, raise mut_done and in_done -> no transition, no pulses, population unchanged.
REQ-035 Mid-run reset test: assert rst in MUT_WAIT -> population=0 on the next edge; in_start re-pulses after release; a later mut_done is ignored until the FSM re-enters MUT_WAIT.
